// File: rtl/alab_pkg.sv
// Shared CPSR layout: flag/control bit positions, mode encodings and reset value.
package alab_pkg;

    localparam int unsigned CPSR_W = 32;
    localparam int unsigned NZCV_W = 4;
    localparam int unsigned MODE_W = 5;

    localparam int unsigned FLAG_N = 31;
    localparam int unsigned FLAG_Z = 30;
    localparam int unsigned FLAG_C = 29;
    localparam int unsigned FLAG_V = 28;

    localparam int unsigned I_BIT   = 7;
    localparam int unsigned MODE_HI = 4;
    localparam int unsigned MODE_LO = 0;

    localparam logic [CPSR_W-1:0] CPSR_RESET_VAL = 32'h0000_00D3;

    localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
    localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
    localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
    localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
    localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
    localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
    localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

endpackage

// File: rtl/status_register_unit.sv
// CPSR/SPSR holder with a one-entry pending flag stage forwarded to condition evaluation.
module status_register_unit
    import alab_pkg::*;
#(
    parameter logic [CPSR_W-1:0] CPSR_RST = CPSR_RESET_VAL,
    parameter logic [MODE_W-1:0] EXC_MODE = MODE_SVC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_valid,
    input  logic                s_bit,
    input  logic                cond_pass,
    input  logic [NZCV_W-1:0]   alu_nzcv,
    input  logic                flush,
    input  logic                msr_we,
    input  logic [CPSR_W-1:0]   msr_data,
    input  logic                exc_entry,
    input  logic                exc_return,
    output logic [CPSR_W-1:0]   status_reg_out,
    output logic [CPSR_W-1:0]   spsr_out,
    output logic                pend_valid
);

    logic [CPSR_W-1:0] cpsr;
    logic [CPSR_W-1:0] spsr;
    logic [NZCV_W-1:0] pend_nzcv;

    logic [CPSR_W-1:0] cpsr_nxt;
    logic [CPSR_W-1:0] spsr_nxt;
    logic [NZCV_W-1:0] pend_nzcv_nxt;
    logic              pend_valid_nxt;
    logic              accept;

    // Any higher-priority CPSR writer or a flush blocks a new flag update.
    assign accept = upd_valid & s_bit & cond_pass & ~flush
                  & ~msr_we & ~exc_entry & ~exc_return;

    // Pending flags bypass the architectural CPSR so the next instruction sees them at once.
    assign status_reg_out = pend_valid ? {pend_nzcv, cpsr[FLAG_V-1:0]} : cpsr;
    assign spsr_out       = spsr;

    always_comb begin
        cpsr_nxt       = cpsr;
        spsr_nxt       = spsr;
        pend_nzcv_nxt  = pend_nzcv;
        pend_valid_nxt = 1'b0;

        if (exc_entry) begin
            spsr_nxt                    = status_reg_out;
            cpsr_nxt[FLAG_N:FLAG_V]     = status_reg_out[FLAG_N:FLAG_V];
            cpsr_nxt[I_BIT]             = 1'b1;
            cpsr_nxt[MODE_HI:MODE_LO]   = EXC_MODE;
        end else if (exc_return) begin
            cpsr_nxt = spsr;
        end else if (msr_we) begin
            cpsr_nxt = msr_data;
        end else begin
            // Older entry retires while a new one may be captured in the same cycle.
            if (pend_valid && !flush) begin
                cpsr_nxt[FLAG_N:FLAG_V] = pend_nzcv;
            end
            if (accept) begin
                pend_nzcv_nxt  = alu_nzcv;
                pend_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpsr       <= CPSR_RST;
            spsr       <= '0;
            pend_nzcv  <= '0;
            pend_valid <= 1'b0;
        end else begin
            cpsr       <= cpsr_nxt;
            spsr       <= spsr_nxt;
            pend_nzcv  <= pend_nzcv_nxt;
            pend_valid <= pend_valid_nxt;
        end
    end

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based CPSR model.
module tb_status_register_unit;

    localparam logic [31:0] RST_VAL = 32'h0000_00D3;
    localparam logic [4:0]  EXC_M   = 5'b10011;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid, s_bit, cond_pass, flush, msr_we, exc_entry, exc_return;
    logic [3:0]  alu_nzcv;
    logic [31:0] msr_data;
    logic [31:0] status_reg_out, spsr_out;
    logic        pend_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: architectural CPSR/SPSR and a queue of flag updates awaiting commit.
    logic [31:0] m_cpsr, m_spsr;
    logic [3:0]  m_pend[$];

    status_register_unit dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .s_bit(s_bit),
        .cond_pass(cond_pass), .alu_nzcv(alu_nzcv), .flush(flush),
        .msr_we(msr_we), .msr_data(msr_data), .exc_entry(exc_entry),
        .exc_return(exc_return), .status_reg_out(status_reg_out),
        .spsr_out(spsr_out), .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_view();
        if (m_pend.size() != 0) return {m_pend[0], m_cpsr[27:0]};
        return m_cpsr;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "/view"}, status_reg_out, m_view());
        check({tag, "/spsr"}, spsr_out, m_spsr);
        check({tag, "/pend"}, 32'(pend_valid), 32'(m_pend.size() != 0));
    endtask

    task automatic idle_inputs();
        upd_valid = 0; s_bit = 0; cond_pass = 0; flush = 0; msr_we = 0;
        exc_entry = 0; exc_return = 0; alu_nzcv = '0; msr_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        m_cpsr = RST_VAL; m_spsr = '0; m_pend.delete();
        check("rst/view", status_reg_out, RST_VAL);
        check("rst/spsr", spsr_out, 32'h0);
        check("rst/pend", 32'(pend_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by the priority rules, compare after the edge.
    task automatic cycle(input logic uv, input logic sb, input logic cp, input logic fl,
                         input logic mw, input logic [31:0] md, input logic ee,
                         input logic er, input logic [3:0] nz);
        logic [31:0] fwd;
        upd_valid = uv; s_bit = sb; cond_pass = cp; flush = fl; msr_we = mw;
        msr_data = md; exc_entry = ee; exc_return = er; alu_nzcv = nz;
        #1;
        fwd = m_view();
        check("pre/view", status_reg_out, fwd);
        if (ee) begin
            m_spsr = fwd;
            m_cpsr = {fwd[31:28], m_cpsr[27:8], 1'b1, m_cpsr[6:5], EXC_M};
            m_pend.delete();
        end else if (er) begin
            m_cpsr = m_spsr;
            m_pend.delete();
        end else if (mw) begin
            m_cpsr = md;
            m_pend.delete();
        end else begin
            if (m_pend.size() != 0) begin
                if (fl) m_pend.delete();
                else m_cpsr[31:28] = m_pend.pop_front();
            end
            if (uv && sb && cp && !fl) m_pend.push_back(nz);
        end
        @(posedge clk);
        #1;
        check_model("post");
    endtask

    task automatic accept(input logic [3:0] nz);
        cycle(1, 1, 1, 0, 0, '0, 0, 0, nz);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, '0, 0, 0, 4'h0);
    endtask

    initial begin
        logic [31:0] r;
        idle_inputs();
        rst = 1'b0;
        #3;
        do_reset();

        // Accepted flags forward immediately, then retire into CPSR.
        accept(4'b0100);
        check("a/view", status_reg_out, 32'h4000_00D3);
        check("a/pend", 32'(pend_valid), 32'h1);
        idle();
        check("a/commit", status_reg_out, 32'h4000_00D3);
        check("a/pend0", 32'(pend_valid), 32'h0);

        // Condition-failed instruction leaves flags alone.
        do_reset();
        cycle(1, 1, 0, 0, 0, '0, 0, 0, 4'b1000);
        check("b/view", status_reg_out, 32'h0000_00D3);
        check("b/pend", 32'(pend_valid), 32'h0);

        // Flush the cycle after acceptance discards the entry.
        do_reset();
        accept(4'b0010);
        cycle(0, 0, 0, 1, 0, '0, 0, 0, 4'h0);
        check("c/view", status_reg_out, 32'h0000_00D3);
        check("c/pend", 32'(pend_valid), 32'h0);

        // Back-to-back accepts.
        do_reset();
        accept(4'b0001);
        check("d/first", status_reg_out, 32'h1000_00D3);
        accept(4'b1100);
        check("d/second", status_reg_out, 32'hC000_00D3);
        idle();
        check("d/final", status_reg_out, 32'hC000_00D3);

        // MSR overrides a pending commit.
        do_reset();
        accept(4'b0110);
        cycle(0, 0, 0, 0, 1, 32'hF000_0010, 0, 0, 4'h0);
        check("e/view", status_reg_out, 32'hF000_0010);
        check("e/pend", 32'(pend_valid), 32'h0);

        // Exception entry/return, then reset mid-sequence.
        cycle(0, 0, 0, 0, 1, 32'h2000_0010, 0, 0, 4'h0);
        cycle(0, 0, 0, 0, 0, '0, 1, 0, 4'h0);
        check("f/spsr", spsr_out, 32'h2000_0010);
        check("f/entry", status_reg_out, 32'h2000_0093);
        cycle(0, 0, 0, 0, 0, '0, 0, 1, 4'h0);
        check("f/return", status_reg_out, 32'h2000_0010);
        cycle(0, 0, 0, 0, 0, '0, 1, 0, 4'h0);
        do_reset();
        check("f/rst", status_reg_out, 32'h0000_00D3);

        // Exception entry while an update is pending saves the forwarded flags.
        accept(4'b1010);
        cycle(1, 1, 1, 0, 0, '0, 1, 0, 4'b0101);
        check("g/spsr", spsr_out, 32'hA000_00D3);
        check("g/entry", status_reg_out, 32'hA000_00D3);

        // Randomized traffic with rare control events.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(r[0] | r[1], r[2] | r[3], r[4] | r[5],
                  r[8:6] == 3'd0, r[11:9] == 3'd0,
                  $urandom, r[15:12] == 4'd0, r[19:16] == 4'd0, r[23:20]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
